// File: rtl/fp_pkg.sv
// Shared FP definitions: flag bit positions, precision tags, canonical NaNs
// and the packed record that travels through the result queue.
package fp_pkg;

    localparam int FLAG_W = 5;
    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    localparam logic [31:0] QNAN_SP = 32'h7FC00000;
    localparam logic [15:0] QNAN_HP = 16'h7E00;

    localparam logic MODE_SP = 1'b0;
    localparam logic MODE_HP = 1'b1;

    typedef struct packed {
        logic [31:0]       result;
        logic [FLAG_W-1:0] flags;
        logic              mode_fp;
    } res_entry_t;

    // Half-precision results carry no meaning in the upper half; zero it so
    // writeback never sees stale ALU bits there.
    function automatic logic [31:0] canon_result(input logic [31:0] r, input logic mode);
        return (mode == MODE_HP) ? {16'h0000, r[15:0]} : r;
    endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// DEPTH-entry synchronous FIFO with occupancy count; when empty the head
// output keeps presenting the most recently popped word.
module fp_sync_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic [WIDTH-1:0] last_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH comes for free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            last_reg   <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                last_reg   <= mem[rd_ptr_reg];
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign level     = level_reg;
    assign head_data = (level_reg != '0) ? mem[rd_ptr_reg] : last_reg;

endmodule

// File: rtl/fp_result_queue.sv
// FP ALU result queue: buffers canonicalised results for writeback and keeps
// the sticky exception flags, the masked exception interrupt and an op count.
module fp_result_queue
    import fp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       in_result,
    input  logic [FLAG_W-1:0] in_flags,
    input  logic              in_mode_fp,
    output logic              in_ready,
    output logic              out_valid,
    output logic [31:0]       out_result,
    output logic [FLAG_W-1:0] out_flags,
    output logic              out_mode_fp,
    input  logic              out_ready,
    input  logic              sticky_clr,
    input  logic [FLAG_W-1:0] irq_en,
    output logic [FLAG_W-1:0] sticky_flags,
    output logic              exc_irq,
    output logic [LW-1:0]     level,
    output logic [CNT_W-1:0]  op_count,
    input  logic              cnt_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              push;
    logic              pop;
    res_entry_t        wr_entry;
    res_entry_t        head_entry;
    logic [FLAG_W-1:0] sticky_reg;
    logic [FLAG_W-1:0] sticky_next;
    logic              irq_reg;
    logic [CNT_W-1:0]  count_reg;

    assign in_ready  = (level != LW'(DEPTH));
    assign out_valid = (level != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_entry.result  = canon_result(in_result, in_mode_fp);
        wr_entry.flags   = in_flags;
        wr_entry.mode_fp = in_mode_fp;
    end

    fp_sync_fifo #(
        .WIDTH ($bits(res_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (wr_entry),
        .pop       (pop),
        .head_data (head_entry),
        .level     (level)
    );

    assign out_result  = head_entry.result;
    assign out_flags   = head_entry.flags;
    assign out_mode_fp = head_entry.mode_fp;

    // Clear wipes the old state only; flags arriving in the same cycle survive.
    always_comb begin
        sticky_next = sticky_clr ? '0 : sticky_reg;
        if (push) begin
            sticky_next = sticky_next | in_flags;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_reg <= '0;
            irq_reg    <= 1'b0;
            count_reg  <= '0;
        end else begin
            sticky_reg <= sticky_next;
            irq_reg    <= |(sticky_next & irq_en);
            if (cnt_clr) begin
                count_reg <= push ? CNT_W'(1) : '0;
            end else if (push && (count_reg != CNT_MAX)) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign sticky_flags = sticky_reg;
    assign exc_irq      = irq_reg;
    assign op_count     = count_reg;

endmodule

// File: doc/fp_result_queue.md
Name: fp_result_queue

Overview:
- Downstream stage of the FP ALU. Captures each {result, flags, mode_fp} the ALU produces into a small FIFO and presents it to the consumer (register file / writeback) over a valid/ready handshake.
- Keeps the architectural sticky exception-flag register and a masked exception interrupt.
- Keeps a saturating count of completed operations.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, ≥2).
- CNT_W, 16, width of the operation counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  ALU result valid (driven from ALU valid_out qualified by issue).
- in_result  in  32  ALU result; half precision occupies [15:0].
- in_flags  in  5  ALU flags: [4] invalid, [3] div-by-zero, [2] overflow, [1] underflow, [0] inexact.
- in_mode_fp  in  1  1 = half precision, 0 = single.
- in_ready  out  1  queue can accept.
- out_valid  out  1  head entry valid.
- out_result  out  32  head result.
- out_flags  out  5  head flags.
- out_mode_fp  out  1  head precision tag.
- out_ready  in  1  consumer accepts head.
- sticky_clr  in  1  clear sticky flags.
- irq_en  in  5  per-flag interrupt enable.
- sticky_flags  out  5  accumulated flags.
- exc_irq  out  1  |(sticky_flags & irq_en).
- level  out  $clog2(DEPTH)+1  current occupancy.
- op_count  out  CNT_W  accepted-push count, saturating.
- cnt_clr  in  1  clear op_count.

Behaviour:

Reset (rst low, asynchronous):
- wr/rd pointers = 0, level = 0, out_valid = 0.
- out_result, out_flags, out_mode_fp = 0.
- sticky_flags = 0, op_count = 0, exc_irq = 0.

Handshake:
- push = in_valid & in_ready. in_ready = (level != DEPTH), derived from registers only.
- pop = out_valid & out_ready. out_valid = (level != 0).
- Latency: an entry pushed in cycle N is visible on out_* in cycle N+1. There is no combinational in→out bypass.

Storage:
- On push with in_mode_fp = 1, store in_result[31:16] forced to 0, so downstream always sees a canonical half-precision result.
- out_* show the head entry combinationally from storage. They hold stable while out_valid & ~out_ready.
- When level = 0, out_* retain the last popped values. They are don't-care for the consumer.

Simultaneous events:
- push & pop in the same cycle: level unchanged, both pointers advance.
- Full: in_ready = 0, so no push. A pop in that cycle frees a slot for the next cycle, not the current one.
- Empty: out_valid = 0, so no pop.
- Pointers wrap modulo DEPTH.

Sticky flags:
- On push: sticky_flags <= sticky_flags | in_flags.
- sticky_clr alone: sticky_flags <= 0.
- sticky_clr with push in the same cycle: sticky_flags <= in_flags (clear applies to old state, new flags kept).

exc_irq:
- Registered: exc_irq <= |(next sticky_flags & irq_en). It asserts one cycle after the causing push.
- Changing irq_en takes effect the next cycle.

op_count:
- +1 per push, saturates at 2^CNT_W−1.
- cnt_clr sets it to 0. If a push coincides, it is set to 1.

Reset asserted mid-operation discards all entries and flags immediately. There is no drain.

Decomposition:
- Shared package fp_pkg:
  - flag bit indices (FLG_NV=4, FLG_DZ=3, FLG_OF=2, FLG_UF=1, FLG_NX=0);
  - FLAG_W=5;
  - canonical qNaN constants QNAN_SP=32'h7FC00000 and QNAN_HP=16'h7E00;
  - mode encoding (MODE_SP=0, MODE_HP=1).
- One sub-module, fp_sync_fifo: parameterised-width DEPTH-entry storage, pointers and level.
- The top level adds canonicalisation, sticky flags, irq and counter.

Test Plan:
1. Reset then single push: in_result=32'h40400000, flags=5'b00000, mode=0 → next cycle out_valid=1, out_result=32'h40400000, level=1; out_ready=1 → level=0, op_count=1.
2. Half-precision canonicalise: push in_result=32'hDEAD3C00, mode=1 → out_result=32'h00003C00, out_mode_fp=1.
3. Fill/backpressure: out_ready=0, push 5 consecutive → first 4 accepted, in_ready=0 from the cycle after the 4th push, level=4; the 5th is held until one pop, then accepted. Pop order equals push order.
4. Sticky/irq: irq_en=5'b01000; push flags 5'b00001 then 5'b01000 → sticky=5'b01001, exc_irq rises one cycle after the second push; sticky_clr with simultaneous push flags 5'b00100 → sticky=5'b00100, exc_irq falls.
5. Simultaneous push/pop at level=2 for 10 cycles → level stays 2, data order preserved across pointer wrap.
6. Async reset mid-stream: level=3, drop rst between edges → out_valid, level, sticky_flags, exc_irq, op_count read 0 immediately; first push after release appears normally.
